// File: rtl/fpa_share_ctrl.sv
// rtl/fpa_share_ctrl.sv - round-robin controller sharing one FP adder among N_REQ clients (option macro: FPA_TIMEOUT_EN)
module fpa_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] opA,
  input  logic [32*N_REQ-1:0] opB,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [31:0]         res,
  output logic [2:0]          res_id,
  output logic                err,
  output logic                busy,
  output logic [31:0]         fpa_A,
  output logic [31:0]         fpa_B,
  output logic                fpa_start,
  input  logic                fpa_done,
  input  logic [31:0]         fpa_ans
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         res_id_q, res_id_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [31:0]        fpa_a_q, fpa_a_d;
  logic [31:0]        fpa_b_q, fpa_b_d;
  logic               fpa_start_q, fpa_start_d;
  logic               done_prev_q, done_prev_d;

`ifdef FPA_TIMEOUT_EN
  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  logic [7:0]  req_ext;
  logic [3:0]  scan_idx;
  logic        found;
  logic [2:0]  win;
  logic [31:0] win_a, win_b;

  // Round-robin pick: first requester at or above ptr, wrapping modulo N_REQ
  always_comb begin
    req_ext  = 8'(req);
    found    = 1'b0;
    win      = 3'd0;
    scan_idx = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + 4'(k);
      if (scan_idx >= 4'(N_REQ)) scan_idx = scan_idx - 4'(N_REQ);
      if (!found && req_ext[scan_idx[2:0]]) begin
        found = 1'b1;
        win   = scan_idx[2:0];
      end
    end
  end

  // Operand slices of the arbitration winner
  always_comb begin
    win_a = 32'd0;
    win_b = 32'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == 3'(i)) begin
        win_a = opA[32*i +: 32];
        win_b = opB[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic of the scheduler FSM
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = '0;
    ack_d       = '0;
    res_d       = res_q;
    res_id_d    = res_id_q;
    err_d       = 1'b0;
    fpa_a_d     = fpa_a_q;
    fpa_b_d     = fpa_b_q;
    fpa_start_d = 1'b0;
    // previous-cycle done level; a level left high across START never looks like an edge
    done_prev_d = fpa_done;
`ifdef FPA_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = win;
          fpa_a_d = win_a;
          fpa_b_d = win_b;
          for (int i = 0; i < N_REQ; i++) gnt_d[i] = (win == 3'(i));
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        fpa_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
`ifdef FPA_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fpa_done && !done_prev_q) begin
          res_d    = fpa_ans;
          res_id_d = id_q;
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (id_q == 3'(i));
          state_d  = S_DONE;
        end
`ifdef FPA_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d    = QNAN;
          res_id_d = id_q;
          err_d    = 1'b1;
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (id_q == 3'(i));
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        ptr_d   = (id_q == 3'(N_REQ - 1)) ? 3'd0 : id_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      id_q        <= 3'd0;
      gnt_q       <= '0;
      ack_q       <= '0;
      res_q       <= 32'd0;
      res_id_q    <= 3'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      fpa_a_q     <= 32'd0;
      fpa_b_q     <= 32'd0;
      fpa_start_q <= 1'b0;
      done_prev_q <= 1'b0;
`ifdef FPA_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      fpa_a_q     <= fpa_a_d;
      fpa_b_q     <= fpa_b_d;
      fpa_start_q <= fpa_start_d;
      done_prev_q <= done_prev_d;
`ifdef FPA_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign fpa_A     = fpa_a_q;
  assign fpa_B     = fpa_b_q;
  assign fpa_start = fpa_start_q;

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// tb/tb_fpa_share_ctrl.sv - directed self-checking bench for fpa_share_ctrl
module tb_fpa_share_ctrl;

  localparam int N_REQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] opA, opB;
  logic [N_REQ-1:0]    gnt, ack;
  logic [31:0]         res;
  logic [2:0]          res_id;
  logic                err, busy;
  logic [31:0]         fpa_A, fpa_B;
  logic                fpa_start;
  logic                fpa_done;
  logic [31:0]         fpa_ans;

  int n_checks = 0;
  int n_errors = 0;

  logic             model_en   = 1'b0;
  logic             model_hold = 1'b0;
  int               model_lat  = 1;
  logic [N_REQ-1:0] hold_mask  = '0;

  int cyc         = 0;
  int last_start  = -1;
  int min_gap     = 1000;
  int start_count = 0;
  int ack_count   = 0;

  fpa_share_ctrl #(.N_REQ(N_REQ), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .opA(opA), .opB(opB),
    .gnt(gnt), .ack(ack), .res(res), .res_id(res_id), .err(err), .busy(busy),
    .fpa_A(fpa_A), .fpa_B(fpa_B), .fpa_start(fpa_start),
    .fpa_done(fpa_done), .fpa_ans(fpa_ans)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fadd_tab(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      64'h40800000_40800000: return 32'h41000000;
      64'h3F800000_3F000000: return 32'h3FC00000;
      64'h3F800000_3F800000: return 32'h40000000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    opA[32*i +: 32] = a;
    opB[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (fpa_start) return;
    end
    check_eq("start_seen", 32'(fpa_start), 32'd1);
  endtask

  task automatic wait_ack(input int max_cyc, output logic [N_REQ-1:0] a, output logic [31:0] r,
                          output logic [2:0] id, output logic e, output int lat);
    a = '0; r = 32'd0; id = 3'd0; e = 1'b0; lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        a = ack; r = res; id = res_id; e = err; lat = i;
        req = req & ~(ack & ~hold_mask);
        return;
      end
    end
    check_eq("ack_seen", 32'(ack != '0), 32'd1);
  endtask

  // adder stand-in: answers lat cycles after the start pulse with a hand-computed sum
  initial begin
    fpa_done = 1'b0;
    fpa_ans  = 32'd0;
    forever begin
      @(posedge clk); #2;
      if (model_en && fpa_start) begin
        repeat (model_lat) @(posedge clk);
        #2;
        fpa_ans  = fadd_tab(fpa_A, fpa_B);
        fpa_done = 1'b1;
        @(posedge clk); #2;
        if (!model_hold) fpa_done = 1'b0;
      end
    end
  end

  // start spacing and ack counting
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fpa_start) begin
      if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
      last_start = cyc;
      start_count++;
    end
    if (ack != '0) ack_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N_REQ-1:0] a;
    logic [31:0]      r;
    logic [2:0]       id;
    logic             e;
    int               lat;
    int               base;
    logic [31:0]      exp_res [4];

    req = '0; opA = '0; opB = '0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_res", res, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(fpa_start), 32'd0);
    check_eq("rst_fpa_a", fpa_A, 32'd0);

    // single request 1.0 + 2.0
    model_en = 1'b1; model_lat = 2;
    set_op(0, 32'h3F800000, 32'h40000000);
    req = 4'b0001;
    @(posedge clk); #1;
    check_eq("t1_gnt", 32'(gnt), 32'h1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_fpa_a", fpa_A, 32'h3F800000);
    check_eq("t1_fpa_b", fpa_B, 32'h40000000);
    @(posedge clk); #1;
    check_eq("t1_start", 32'(fpa_start), 32'd1);
    check_eq("t1_gnt_off", 32'(gnt), 32'd0);
    wait_ack(20, a, r, id, e, lat);
    check_eq("t1_ack", 32'(a), 32'h1);
    check_eq("t1_res", r, 32'h40400000);
    check_eq("t1_id", 32'(id), 32'd0);
    check_eq("t1_err", 32'(e), 32'd0);
    check_eq("t1_lat", 32'(lat), 32'd3);

    // all four at once from ptr=0
    do_reset();
    model_lat = 1;
    set_op(0, 32'h3F800000, 32'h40000000); exp_res[0] = 32'h40400000;
    set_op(1, 32'h40000000, 32'h40000000); exp_res[1] = 32'h40800000;
    set_op(2, 32'h3F000000, 32'h3F000000); exp_res[2] = 32'h3F800000;
    set_op(3, 32'h40800000, 32'h40800000); exp_res[3] = 32'h41000000;
    last_start = -1; min_gap = 1000; start_count = 0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(30, a, r, id, e, lat);
      check_eq($sformatf("t2_id%0d", i), 32'(id), 32'(i));
      check_eq($sformatf("t2_ack%0d", i), 32'(a), 32'(1 << i));
      check_eq($sformatf("t2_res%0d", i), r, exp_res[i]);
    end
    @(posedge clk); #1;
    check_eq("t2_starts", 32'(start_count), 32'd4);
    check_eq("t2_min_gap", 32'(min_gap), 32'd5);

    // fairness: req[1] held, req[2] joins after first grant
    do_reset();
    set_op(1, 32'h3F800000, 32'h3F000000);
    set_op(2, 32'h40800000, 32'h40800000);
    hold_mask = 4'b0010;
    req = 4'b0010;
    wait_start(10);
    req[2] = 1'b1;
    wait_ack(30, a, r, id, e, lat);
    check_eq("t3_id0", 32'(id), 32'd1);
    check_eq("t3_res0", r, 32'h3FC00000);
    wait_ack(30, a, r, id, e, lat);
    check_eq("t3_id1", 32'(id), 32'd2);
    check_eq("t3_res1", r, 32'h41000000);
    wait_ack(30, a, r, id, e, lat);
    check_eq("t3_id2", 32'(id), 32'd1);
    hold_mask = '0;
    req = '0;

    // reset during WAIT, then a stray done
    do_reset();
    model_en = 1'b0;
    set_op(0, 32'h3F800000, 32'h40000000);
    req = 4'b0001;
    wait_start(10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; req = '0;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_res", res, 32'd0);
    check_eq("t4_res_id", 32'(res_id), 32'd0);
    check_eq("t4_fpa_a", fpa_A, 32'd0);
    check_eq("t4_fpa_b", fpa_B, 32'd0);
    base = ack_count;
    fpa_ans = 32'h12345678; fpa_done = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t4_no_ack", 32'(ack_count - base), 32'd0);
    check_eq("t4_busy_after", 32'(busy), 32'd0);
    check_eq("t4_res_after", res, 32'd0);
    fpa_done = 1'b0;
    @(posedge clk); #1;

    // done left high from the previous op
    model_en = 1'b1; model_hold = 1'b1; model_lat = 1;
    set_op(0, 32'h3F800000, 32'h3F800000);
    req = 4'b0001;
    wait_ack(30, a, r, id, e, lat);
    check_eq("t5_res0", r, 32'h40000000);
    model_en = 1'b0;
    set_op(2, 32'h3F000000, 32'h3F000000);
    req = 4'b0100;
    wait_start(10);
    base = ack_count;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t5_held_done", 32'(fpa_done), 32'd1);
    check_eq("t5_no_early_ack", 32'(ack_count - base), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd1);
    fpa_done = 1'b0;
    @(posedge clk); #1;
    fpa_ans = 32'h3F800000; fpa_done = 1'b1;
    wait_ack(5, a, r, id, e, lat);
    check_eq("t5_ack", 32'(a), 32'h4);
    check_eq("t5_res", r, 32'h3F800000);
    check_eq("t5_lat", 32'(lat), 32'd1);
    fpa_done = 1'b0; model_hold = 1'b0;

`ifdef FPA_TIMEOUT_EN
    // adder never answers: timeout after 8 WAIT cycles
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40000000, 32'h40000000);
    req = 4'b0001;
    wait_start(10);
    wait_ack(20, a, r, id, e, lat);
    check_eq("t6_lat", 32'(lat), 32'd9);
    check_eq("t6_err", 32'(e), 32'd1);
    check_eq("t6_res", r, 32'h7FC00000);
    check_eq("t6_id", 32'(id), 32'd0);
    @(posedge clk); #1;
    check_eq("t6_err_clear", 32'(err), 32'd0);
    model_en = 1'b1; model_lat = 1;
    req = 4'b0011;
    wait_ack(30, a, r, id, e, lat);
    check_eq("t6_ptr_adv", 32'(id), 32'd1);
    check_eq("t6_res1", r, 32'h40800000);
    check_eq("t6_err1", 32'(e), 32'd0);
    req = '0;
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
